// File: rtl/jesd204_fec_pkg.sv
// Shared constants, FSM state type and the serial parity step for the JESD204C
// transmit FEC path (g(x) = x^26 + x^21 + x^17 + x^9 + x^4 + 1).
package jesd204_fec_pkg;

    localparam int unsigned FEC_WIDTH     = 26;
    localparam int unsigned BLOCKS_PER_MB = 32;
    localparam int unsigned BLOCK_BITS    = 64;

    // Generator polynomial without the implicit x^26 term.
    localparam logic [FEC_WIDTH-1:0] FEC_POLY = 26'h0220211;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_RUN    = 1'b1
    } fec_state_e;

    // Absorb one block into the parity remainder; bit 0 is the first bit on the wire.
    function automatic logic [FEC_WIDTH-1:0] fec_step(
        input logic [FEC_WIDTH-1:0]  state,
        input logic [BLOCK_BITS-1:0] data
    );
        logic [FEC_WIDTH-1:0] r;
        logic                 fb;
        r = state;
        for (int unsigned i = 0; i < BLOCK_BITS; i++) begin
            fb = data[i] ^ r[FEC_WIDTH-1];
            r  = {r[FEC_WIDTH-2:0], 1'b0} ^ (fb ? FEC_POLY : '0);
        end
        return r;
    endfunction

endpackage

// File: rtl/jesd204_fec_encode.sv
// Per-multiblock parity accumulator: absorbs one 64-bit block per shift_en,
// cleared by a synchronous rst.
module jesd204_fec_encode #(
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [25:0]           fec
);
    import jesd204_fec_pkg::*;

    logic [FEC_WIDTH-1:0] fec_q;

    // rst clears before absorbing, so a beat 0 landing on the clearing edge is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            fec_q <= shift_en ? fec_step('0, data_in) : '0;
        end else if (shift_en) begin
            fec_q <= fec_step(fec_q, data_in);
        end
    end

    assign fec = fec_q;

endmodule

// File: rtl/jesd204_fec_encode_ctrl.sv
// Multiblock sequencer for the JESD204C TX FEC: aligns to the upstream
// multiblock start and ping-pongs two parity encoders with no bubble.
module jesd204_fec_encode_ctrl #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned FEC_WIDTH     = 26,
    parameter int unsigned BLOCKS_PER_MB = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    input  logic                  in_mb_start,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [FEC_WIDTH-1:0]  fec_out,
    output logic                  fec_valid,
    output logic                  mb_index,
    output logic                  align_err
);
    import jesd204_fec_pkg::*;

    localparam int unsigned          CNT_W    = $clog2(BLOCKS_PER_MB);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BLOCKS_PER_MB - 1);

    fec_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  shift_q, shift_d;
    logic                  enc_q, enc_d;
    logic                  last_q, last_d;
    logic                  done_q;
    logic                  done_enc_q;
    logic [1:0]            rst_q, rst_d;
    logic                  align_err_q, align_err_d;
    logic [FEC_WIDTH-1:0]  fec_q;
    logic                  fec_valid_q;
    logic                  mb_index_q;
    logic [FEC_WIDTH-1:0]  enc_fec [2];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        shift_d     = 1'b0;
        enc_d       = sel_q;
        last_d      = 1'b0;
        align_err_d = 1'b0;
        rst_d       = '0;
        if (done_q) begin
            rst_d[done_enc_q] = 1'b1;
        end
        if (in_valid) begin
            unique case (state_q)
                ST_SEARCH: begin
                    if (in_mb_start) begin
                        state_d = ST_RUN;
                        shift_d = 1'b1;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    shift_d = 1'b1;
                    if (in_mb_start && (cnt_q != '0)) begin
                        // Abort: scrub the partial encoder, restart beat 0 on the other one.
                        align_err_d  = 1'b1;
                        rst_d[sel_q] = 1'b1;
                        sel_d        = ~sel_q;
                        enc_d        = ~sel_q;
                        cnt_d        = CNT_W'(1);
                    end else begin
                        last_d = (cnt_q == CNT_LAST);
                        cnt_d  = last_d ? '0 : cnt_q + CNT_W'(1);
                        if (last_d) begin
                            sel_d = ~sel_q;
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_SEARCH;
            cnt_q       <= '0;
            sel_q       <= 1'b0;
            data_q      <= '0;
            shift_q     <= 1'b0;
            enc_q       <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            done_enc_q  <= 1'b0;
            rst_q       <= '1;
            align_err_q <= 1'b0;
            fec_q       <= '0;
            fec_valid_q <= 1'b0;
            mb_index_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            data_q      <= in_data;
            shift_q     <= shift_d;
            enc_q       <= enc_d;
            last_q      <= last_d;
            done_q      <= shift_q && last_q;
            done_enc_q  <= enc_q;
            rst_q       <= rst_d;
            align_err_q <= align_err_d;
            fec_valid_q <= done_q;
            if (done_q) begin
                fec_q      <= enc_fec[done_enc_q];
                mb_index_q <= done_enc_q;
            end
        end
    end

    jesd204_fec_encode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_enc0 (
        .clk      (clk),
        .rst      (rst_q[0]),
        .shift_en (shift_q && !enc_q),
        .data_in  (data_q),
        .fec      (enc_fec[0])
    );

    jesd204_fec_encode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_enc1 (
        .clk      (clk),
        .rst      (rst_q[1]),
        .shift_en (shift_q && enc_q),
        .data_in  (data_q),
        .fec      (enc_fec[1])
    );

    assign fec_out   = fec_q;
    assign fec_valid = fec_valid_q;
    assign mb_index  = mb_index_q;
    assign align_err = align_err_q;

endmodule

// File: doc/jesd204_fec_encode_ctrl.md
# jesd204_fec_encode_ctrl

Sequences the JESD204C 64B/66B transmit FEC path. The block accepts the lane's 64-bit block stream and groups it into 2048-bit multiblocks of 32 blocks each, aligned to an upstream multiblock-start marker. It feeds each multiblock into one of two ping-ponged `jesd204_fec_encode` instances and presents the 26-bit parity of every completed multiblock to the sync-header/FEC inserter, with no bubble between multiblocks.

## Interface
- `DATA_WIDTH`, 64, block width per beat; only 64 is supported.
- `FEC_WIDTH`, 26, parity width per multiblock.
- `BLOCKS_PER_MB`, 32, beats per multiblock (2048 / DATA_WIDTH).
- `clk`  in  1  lane clock; single clock domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat qualifier; no backpressure exists.
- `in_mb_start`  in  1  marks beat 0 of a multiblock; sampled only with `in_valid`.
- `in_data`  in  DATA_WIDTH  block; bit 0 is the first bit on the wire.
- `fec_out`  out  FEC_WIDTH  parity of the last completed multiblock; held until the next completion.
- `fec_valid`  out  1  one-cycle pulse when `fec_out` updates.
- `mb_index`  out  1  encoder that produced `fec_out` (0/1).
- `align_err`  out  1  one-cycle pulse on a premature `in_mb_start`.

## Operation
- States:
  - SEARCH (after reset): beats are discarded.
  - RUN: entered on `in_valid && in_mb_start`; that beat is beat 0.
- Beat counter `cnt`, 5 bits, 0..31:
  - Advances only on `in_valid`.
  - Wraps from 31 to 0 and toggles the active encoder select `sel`.
- Gaps (`in_valid` low) freeze `cnt`, `sel` and both encoders. A multiblock may span any number of idle cycles.
- Input stage: one register stage holds `in_data` and `in_valid`. The selected encoder gets `shift_en` and `data_in` from this stage. The other encoder sees `shift_en=0`.
- Completion, when beat 31 is absorbed:
  - The controller captures that encoder's `fec` into `fec_out`.
  - It pulses `fec_valid` and sets `mb_index = sel_of_that_mb`.
  - On the next cycle it asserts that encoder's `rst` for one cycle.
- Premature `in_mb_start` in RUN with `cnt != 0`:
  - The partial multiblock is aborted; no `fec_valid` is issued.
  - `align_err` pulses.
  - The aborted encoder is reset.
  - The current beat becomes beat 0 on the other encoder. That encoder is guaranteed clean because it was reset at least 1 cycle after its last completion.
- `in_mb_start` with `cnt == 0` in RUN is the expected case; no error is raised.
- `in_mb_start` absent at a wrap is not an error; the counter free-runs.

## Timing
- Reset (`resetn` low, async):
  - `fec_out = 0`, `fec_valid = 0`, `mb_index = 0`, `align_err = 0`.
  - State SEARCH, `cnt = 0`, `sel = 0`.
  - Both encoder `rst` flops are async-set to 1 and held for the first cycle after release.
- Latency: beat 31 is sampled at edge E0. The encoder absorbs it at E1. `fec_out` and `fec_valid` are registered at E2, a fixed 2-edge latency independent of gaps after beat 31.
- An encoder's `rst` is high during E2..E3 and it is clear by E3. Its next `shift_en` is at least 32 edges later.
- Back-to-back multiblocks: `fec_valid` pulses exactly every 32 valid beats; the two encoders alternate.
- Simultaneous completion capture and premature start on the other encoder: both actions occur. `fec_valid` and `align_err` may pulse in the same cycle.
- Reset mid-multiblock: partial state is discarded, no `fec_valid` is issued, and the block returns to SEARCH.

## Structure
- Constants `FEC_WIDTH`, `BLOCKS_PER_MB`, and the SEARCH/RUN state enum go in `jesd204_fec_pkg`.
- Two instances of the existing `jesd204_fec_encode` sub-module (DATA_WIDTH=64).
- Controller logic: FSM, counter, select, input register, capture register, rst generation.

## Test plan
- All-zero continuous stream, `in_mb_start` every 32 beats -> `fec_valid` every 32 cycles, `fec_out = 26'h0`, `mb_index` alternating 0,1,0.
- Multiblock {1'b1, 2047'b0} sent MSb-first (beat 0 bit 0 = 1), then zeros -> `fec_out` equals a standalone encoder fed the same 32 beats. The following all-zero multiblock gives `26'h0`, which proves the reset.
- Random data with random `in_valid` gaps -> parity matches the gapless golden result. The latency from the beat-31 sample to `fec_valid` is always 2 edges.
- `in_mb_start` at beat 17 -> `align_err` pulse, no `fec_valid` for the aborted multiblock. The next 32 beats give correct parity on the other encoder.
- Beats before any `in_mb_start` after reset -> no `fec_valid`, no `align_err`. The first start gives beat 0 correctly.
- `resetn` asserted at beat 20 -> all outputs go to 0 immediately. After release and a fresh start, the first `fec_out` matches golden.
